// File: rtl/kf_pkg.sv
// Shared types and constants for the Kalman context scheduler slice.
package kf_pkg;

  localparam int WX_DEF = 16;
  localparam int WP_DEF = 32;
  localparam int WF_X   = 15;
  localparam int WF_P   = 29;
  localparam logic signed [WP_DEF-1:0] ONE_P = 32'sh2000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Modular add for indices already known to be below n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/kf_rr_arb.sv
// Round-robin arbiter: first requester at or after the pointer, wrapping.
module kf_rr_arb
  import kf_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  // Scan from the pointer and keep only the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!any_o && req_i[wrap_add(int'(ptr_i), k, N_CH)]) begin
        any_o = 1'b1;
        gnt_o[wrap_add(int'(ptr_i), k, N_CH)] = 1'b1;
        idx_o = CH_W'(wrap_add(int'(ptr_i), k, N_CH));
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/kf_ctx_sched.sv
// Time-shares one scalar Kalman update core among N_CH channels, holding
// per-channel x/P/Q/R context and emitting channel-tagged estimates.
module kf_ctx_sched
  import kf_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int WX      = WX_DEF,
  parameter int WP      = WP_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    s_valid,
  output logic [N_CH-1:0]    s_ready,
  input  logic [N_CH*WX-1:0] s_z,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [WX-1:0]      cfg_x0,
  input  logic [WP-1:0]      cfg_P0,
  input  logic [WP-1:0]      cfg_Q,
  input  logic [WP-1:0]      cfg_R,
  output logic               core_req_valid,
  input  logic               core_req_ready,
  output logic [CH_W-1:0]    core_tag,
  output logic [WX-1:0]      core_z,
  output logic [WX-1:0]      core_x,
  output logic [WP-1:0]      core_P,
  output logic [WP-1:0]      core_Q,
  output logic [WP-1:0]      core_R,
  input  logic               core_rsp_valid,
  input  logic [CH_W-1:0]    core_rsp_tag,
  input  logic [WX-1:0]      core_rsp_x,
  input  logic [WP-1:0]      core_rsp_P,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CH_W-1:0]    m_ch,
  output logic [WX-1:0]      m_x_hat,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_tag
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [N_CH-1:0]   ctx_ok_q, ctx_ok_d;
  logic [WX-1:0]     ctx_x_q [N_CH];
  logic [WX-1:0]     ctx_x_d [N_CH];
  logic [WP-1:0]     ctx_p_q [N_CH];
  logic [WP-1:0]     ctx_p_d [N_CH];
  logic [WP-1:0]     ctx_qn_q [N_CH];
  logic [WP-1:0]     ctx_qn_d [N_CH];
  logic [WP-1:0]     ctx_rn_q [N_CH];
  logic [WP-1:0]     ctx_rn_d [N_CH];
  logic [CH_W-1:0]   ptr_q, ptr_d, tag_q, tag_d;
  logic [WX-1:0]     z_q, z_d, x_q, x_d;
  logic [WP-1:0]     p_q, p_d, qn_q, qn_d, rn_q, rn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cfg_hit_q, cfg_hit_d;
  logic [CH_W-1:0]   m_ch_q, m_ch_d;
  logic [WX-1:0]     m_x_q, m_x_d;
  logic              err_to_q, err_to_d, err_tag_q, err_tag_d;

  logic [N_CH-1:0]   elig_s, arb_gnt_s;
  logic [CH_W-1:0]   arb_idx_s;
  logic              arb_any_s, cfg_in_range_s, hit_now_s, wb_en_s;

  // Channel indices beyond N_CH only exist when N_CH is not a power of two.
  if ((1 << CH_W) > N_CH) begin : g_cfg_chk
    assign cfg_in_range_s = (cfg_ch < CH_W'(N_CH));
  end else begin : g_cfg_all
    assign cfg_in_range_s = 1'b1;
  end

  assign elig_s    = s_valid & ctx_ok_q;
  assign hit_now_s = cfg_we && cfg_in_range_s && (cfg_ch == tag_q);

  kf_rr_arb #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .req_i (elig_s),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .any_o (arb_any_s)
  );

  // Next-state, grant, response handling and context update.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tag_d     = tag_q;
    z_d       = z_q;
    x_d       = x_q;
    p_d       = p_q;
    qn_d      = qn_q;
    rn_d      = rn_q;
    cnt_d     = cnt_q;
    cfg_hit_d = cfg_hit_q;
    m_ch_d    = m_ch_q;
    m_x_d     = m_x_q;
    err_to_d  = err_to_q;
    err_tag_d = err_tag_q;
    ctx_ok_d  = ctx_ok_q;
    ctx_x_d   = ctx_x_q;
    ctx_p_d   = ctx_p_q;
    ctx_qn_d  = ctx_qn_q;
    ctx_rn_d  = ctx_rn_q;
    s_ready   = '0;
    wb_en_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          s_ready   = arb_gnt_s;
          tag_d     = arb_idx_s;
          z_d       = s_z[int'(arb_idx_s)*WX +: WX];
          x_d       = ctx_x_q[arb_idx_s];
          p_d       = ctx_p_q[arb_idx_s];
          qn_d      = ctx_qn_q[arb_idx_s];
          rn_d      = ctx_rn_q[arb_idx_s];
          ptr_d     = (arb_idx_s == CH_W'(N_CH - 1)) ? '0 : arb_idx_s + CH_W'(1);
          cfg_hit_d = cfg_we && cfg_in_range_s && (cfg_ch == arb_idx_s);
          state_d   = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cfg_hit_d = cfg_hit_q | hit_now_s;
        if (core_req_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        cfg_hit_d = cfg_hit_q | hit_now_s;
        if (core_rsp_valid && (core_rsp_tag == tag_q)) begin
          // A configuration write since grant owns the context; still emit.
          wb_en_s = !(cfg_hit_q | hit_now_s);
          m_ch_d  = tag_q;
          m_x_d   = core_rsp_x;
          state_d = ST_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (core_rsp_valid && !((state_q == ST_WAIT) && (core_rsp_tag == tag_q))) begin
      err_tag_d = 1'b1;
    end else begin
      err_tag_d = err_tag_d;
    end

    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && cfg_in_range_s && (cfg_ch == CH_W'(i))) begin
        ctx_ok_d[i] = 1'b1;
        ctx_x_d[i]  = cfg_x0;
        ctx_p_d[i]  = cfg_P0;
        ctx_qn_d[i] = cfg_Q;
        ctx_rn_d[i] = cfg_R;
      end else if (wb_en_s && (tag_q == CH_W'(i))) begin
        ctx_x_d[i] = core_rsp_x;
        ctx_p_d[i] = core_rsp_P;
      end else begin
        ctx_ok_d[i] = ctx_ok_q[i];
      end
    end
  end

  // State and context registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctx_ok_q  <= '0;
      ptr_q     <= '0;
      tag_q     <= '0;
      z_q       <= '0;
      x_q       <= '0;
      p_q       <= '0;
      qn_q      <= '0;
      rn_q      <= '0;
      cnt_q     <= '0;
      cfg_hit_q <= 1'b0;
      m_ch_q    <= '0;
      m_x_q     <= '0;
      err_to_q  <= 1'b0;
      err_tag_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        ctx_x_q[i]  <= '0;
        ctx_p_q[i]  <= '0;
        ctx_qn_q[i] <= '0;
        ctx_rn_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ctx_ok_q  <= ctx_ok_d;
      ptr_q     <= ptr_d;
      tag_q     <= tag_d;
      z_q       <= z_d;
      x_q       <= x_d;
      p_q       <= p_d;
      qn_q      <= qn_d;
      rn_q      <= rn_d;
      cnt_q     <= cnt_d;
      cfg_hit_q <= cfg_hit_d;
      m_ch_q    <= m_ch_d;
      m_x_q     <= m_x_d;
      err_to_q  <= err_to_d;
      err_tag_q <= err_tag_d;
      for (int i = 0; i < N_CH; i++) begin
        ctx_x_q[i]  <= ctx_x_d[i];
        ctx_p_q[i]  <= ctx_p_d[i];
        ctx_qn_q[i] <= ctx_qn_d[i];
        ctx_rn_q[i] <= ctx_rn_d[i];
      end
    end
  end

  assign core_req_valid = (state_q == ST_ISSUE);
  assign core_tag       = tag_q;
  assign core_z         = z_q;
  assign core_x         = x_q;
  assign core_P         = p_q;
  assign core_Q         = qn_q;
  assign core_R         = rn_q;
  assign m_valid        = (state_q == ST_OUT);
  assign m_ch           = m_ch_q;
  assign m_x_hat        = m_x_q;
  assign busy           = (state_q != ST_IDLE);
  assign err_timeout    = err_to_q;
  assign err_tag        = err_tag_q;

endmodule

// File: tb/tb_kf_ctx_sched.sv
// Directed bench for kf_ctx_sched with a behavioural scalar Kalman core.
module tb_kf_ctx_sched;
  import kf_pkg::*;

  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int WX   = 16;
  localparam int WP   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_CH-1:0]    s_valid, s_ready;
  logic [N_CH*WX-1:0] s_z;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [WX-1:0]      cfg_x0;
  logic [WP-1:0]      cfg_P0, cfg_Q, cfg_R;
  logic               core_req_valid, core_req_ready;
  logic [CH_W-1:0]    core_tag;
  logic [WX-1:0]      core_z, core_x;
  logic [WP-1:0]      core_P, core_Q, core_R;
  logic               core_rsp_valid;
  logic [CH_W-1:0]    core_rsp_tag;
  logic [WX-1:0]      core_rsp_x;
  logic [WP-1:0]      core_rsp_P;
  logic               m_valid, m_ready;
  logic [CH_W-1:0]    m_ch;
  logic [WX-1:0]      m_x_hat;
  logic               busy, err_timeout, err_tag;

  int     n_pass  = 0;
  int     n_total = 0;
  int     core_mode = 0;  // 0 normal, 1 silent, 2 wrong tag first
  longint last_x, last_p, last_q, last_r;

  kf_ctx_sched #(.N_CH(N_CH), .CH_W(CH_W), .WX(WX), .WP(WP), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_z(s_z),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_x0(cfg_x0), .cfg_P0(cfg_P0),
    .cfg_Q(cfg_Q), .cfg_R(cfg_R),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_tag(core_tag), .core_z(core_z), .core_x(core_x), .core_P(core_P),
    .core_Q(core_Q), .core_R(core_R),
    .core_rsp_valid(core_rsp_valid), .core_rsp_tag(core_rsp_tag),
    .core_rsp_x(core_rsp_x), .core_rsp_P(core_rsp_P),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_x_hat(m_x_hat),
    .busy(busy), .err_timeout(err_timeout), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  // Behavioural core: K=Pp/(Pp+R), x'=x+K(z-x), P'=(1-K)Pp, latency 8.
  initial begin
    longint x, z, pp, r, k, xn, pn;
    int     tg, mode;
    core_rsp_valid = 1'b0;
    core_rsp_tag   = '0;
    core_rsp_x     = '0;
    core_rsp_P     = '0;
    forever begin
      @(negedge clk);
      if (core_req_valid && core_req_ready && !rst) begin
        mode   = core_mode;
        tg     = int'(core_tag);
        x      = longint'($signed(core_x));
        z      = longint'($signed(core_z));
        last_x = x;
        last_p = longint'($signed(core_P));
        last_q = longint'($signed(core_Q));
        last_r = longint'($signed(core_R));
        pp     = last_p + last_q;
        r      = last_r;
        k      = ((pp + r) != 0) ? ((pp <<< WF_P) / (pp + r)) : 0;
        xn     = x + ((k * (z - x)) >>> WF_P);
        pn     = ((longint'(ONE_P) - k) * pp) >>> WF_P;
        @(posedge clk);
        if (mode != 1) begin
          repeat (8) @(posedge clk);
          if (mode == 2) begin
            #1;
            core_rsp_valid = 1'b1;
            core_rsp_tag   = CH_W'((tg + 1) % N_CH);
            core_rsp_x     = 16'h7FFF;
            core_rsp_P     = '0;
            @(posedge clk);
            #1 core_rsp_valid = 1'b0;
            @(posedge clk);
          end
          #1;
          core_rsp_valid = 1'b1;
          core_rsp_tag   = CH_W'(tg);
          core_rsp_x     = WX'(xn);
          core_rsp_P     = WP'(pn);
          @(posedge clk);
          #1 core_rsp_valid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_cfg(input int ch, input int x0, input longint p0, input longint q, input longint r);
    cfg_we = 1'b1;
    cfg_ch = CH_W'(ch);
    cfg_x0 = WX'(x0);
    cfg_P0 = WP'(p0);
    cfg_Q  = WP'(q);
    cfg_R  = WP'(r);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arrive"}, 64'(n < 200), 64'd1);
  endtask

  task automatic take_out(input string tag, input int ch, input int x);
    wait_out(tag);
    chk({tag, "_ch"}, 64'(m_ch), 64'(ch));
    chk({tag, "_x"}, 64'(m_x_hat), 64'(x));
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] acc;
    logic       seen;
    int         n;
    int         exp_ch [6];
    int         exp_x  [6];
    exp_ch = '{0, 1, 2, 3, 0, 1};
    exp_x  = '{500, 1000, 1500, 2000, 666, 1333};
    rst = 1'b1; s_valid = '0; s_z = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_x0 = '0; cfg_P0 = '0; cfg_Q = '0; cfg_R = '0;
    core_req_ready = 1'b1; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and no grants without configured contexts.
    chk("rst_flags", 64'({s_ready, core_req_valid, m_valid, busy, err_timeout, err_tag}), 64'd0);
    chk("rst_core_xz", 64'({core_tag, core_z, core_x}), 64'd0);
    chk("rst_core_pqr", 64'(core_P | core_Q | core_R), 64'd0);
    chk("rst_m", 64'({m_ch, m_x_hat}), 64'd0);
    s_valid = 4'hF;
    acc = '0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1 acc = acc | s_ready;
      seen = seen | busy;
      @(negedge clk);
    end
    chk("noctx_ready", 64'(acc), 64'd0);
    chk("noctx_busy", 64'(seen), 64'd0);
    s_valid = '0;

    // Single channel, two updates.
    do_cfg(0, 0, 64'd1 << 29, 0, 64'd1 << 29);
    s_z[0 +: 16] = 16'd1000;
    s_valid = 4'b0001;
    #1 chk("single_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = '0;
    chk("single_req_valid", 64'(core_req_valid), 64'd1);
    take_out("single1", 0, 500);
    chk("single1_reqP", 64'(last_p), 64'd1 << 29);
    s_valid = 4'b0001;
    @(negedge clk);
    s_valid = '0;
    take_out("single2", 0, 666);
    chk("single2_reqP", 64'(last_p), 64'd1 << 28);
    chk("single2_reqx", 64'(last_x), 64'd500);

    // Round-robin fairness from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_cfg(i, 0, 64'd1 << 29, 0, 64'd1 << 29);
      s_z[i*16 +: 16] = 16'(1000 * (i + 1));
    end
    s_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      wait_out("rr");
      chk($sformatf("rr%0d_ch", k), 64'(m_ch), 64'(exp_ch[k]));
      chk($sformatf("rr%0d_x", k), 64'(m_x_hat), 64'(exp_x[k]));
      if (k == 5) s_valid = '0;
      @(negedge clk);
    end

    // Backpressure: pointer is at 2; ch3 stays requesting during OUT.
    do_cfg(2, 0, 64'd1 << 29, 0, 64'd1 << 29);
    s_valid = 4'b1100;
    m_ready = 1'b0;
    #1 chk("bp_grant", 64'(s_ready), 64'b0100);
    @(negedge clk);
    s_valid = 4'b1000;
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), 64'({m_valid, m_ch, m_x_hat, s_ready}),
          64'({1'b1, 2'd2, 16'd1500, 4'b0000}));
      @(negedge clk);
    end
    m_ready = 1'b1;
    s_valid = '0;
    @(negedge clk);
    chk("bp_idle", 64'({busy, m_valid}), 64'd0);

    // Timeout with a silent core; context must survive.
    core_mode = 1;
    do_cfg(1, 100, 64'd1 << 29, 0, 64'd1 << 29);
    s_z[16 +: 16] = 16'd500;
    s_valid = 4'b0010;
    @(negedge clk);
    s_valid = '0;
    n = 0; seen = 1'b0;
    while (!err_timeout && n < 150) begin
      seen = seen | m_valid;
      @(negedge clk);
      n++;
    end
    chk("to_flag", 64'(err_timeout), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_no_out", 64'(seen), 64'd0);
    chk("to_no_tagerr", 64'(err_tag), 64'd0);

    // Wrong-tag response first, then the correct one.
    core_mode = 2;
    s_valid = 4'b0010;
    @(negedge clk);
    s_valid = '0;
    take_out("tagerr", 1, 300);
    chk("tagerr_ctx_x", 64'(last_x), 64'd100);
    chk("tagerr_ctx_p", 64'(last_p), 64'd1 << 29);
    chk("tagerr_flags", 64'({err_tag, err_timeout}), 64'b11);
    core_mode = 0;

    // Configuration write to the in-flight channel wins over writeback.
    do_cfg(0, 0, 64'd1 << 29, 0, 64'd1 << 29);
    s_z[0 +: 16] = 16'd1000;
    s_valid = 4'b0001;
    @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    do_cfg(0, 1234, 64'd1 << 27, 5, 7);
    take_out("coll", 0, 500);
    s_z[0 +: 16] = 16'd2000;
    s_valid = 4'b0001;
    @(negedge clk);
    s_valid = '0;
    take_out("coll2", 0, 1999);
    chk("coll_ctx_x", 64'(last_x), 64'd1234);
    chk("coll_ctx_p", 64'(last_p), 64'd1 << 27);
    chk("coll_ctx_qr", 64'({last_q[15:0], last_r[15:0]}), 64'({16'd5, 16'd7}));

    // Reset while waiting on the core.
    s_z[0 +: 16] = 16'd100;
    s_valid = 4'b0001;
    @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_flags", 64'({core_req_valid, m_valid, busy, err_timeout, err_tag}), 64'd0);
    chk("mid_rst_outs", 64'({m_ch, m_x_hat, core_tag, core_x, core_z}), 64'd0);
    s_valid = 4'hF;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      #1 acc = acc | s_ready;
      @(negedge clk);
    end
    chk("mid_rst_ctx_invalid", 64'(acc), 64'd0);
    n = 0;
    while (!err_tag && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("late_rsp_tagerr", 64'(err_tag), 64'd1);
    chk("late_rsp_idle", 64'({busy, m_valid}), 64'd0);
    s_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d)", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/kf_ctx_sched.md
Name: kf_ctx_sched

Overview:
Context scheduler that time-shares one single-step scalar Kalman update core among N_CH independent sensor channels. Holds per-channel filter context (x, P, Q, R) in registers and arbitrates channel measurements round-robin. Issues one update at a time to the core, writes the returned state back, and presents the channel-tagged estimate downstream. Sits between the sensor front-ends and the shared kf update datapath.

Parameters:
N_CH, 4, number of channels (2..16)
CH_W, $clog2(N_CH), channel index width (derived)
WX, 16, state/measurement width, Q1.15 signed
WP, 32, covariance/noise width, Q3.29 signed
TIMEOUT, 64, max cycles waiting for a core response

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_valid  in  N_CH  per-channel measurement valid
s_ready  out  N_CH  per-channel accept (one-hot or zero)
s_z  in  N_CH*WX  packed measurements, channel i at [i*WX +: WX]
cfg_we  in  1  context write strobe
cfg_ch  in  CH_W  context channel
cfg_x0  in  WX  initial state
cfg_P0  in  WP  initial covariance
cfg_Q  in  WP  process noise
cfg_R  in  WP  measurement noise
core_req_valid  out  1  update request to core
core_req_ready  in  1  core accepts request
core_tag  out  CH_W  channel tag of request
core_z  out  WX  measurement
core_x  out  WX  prior state
core_P  out  WP  prior covariance
core_Q  out  WP  process noise
core_R  out  WP  measurement noise
core_rsp_valid  in  1  one-cycle response pulse
core_rsp_tag  in  CH_W  response tag
core_rsp_x  in  WX  posterior state
core_rsp_P  in  WP  posterior covariance
m_valid  out  1  estimate valid
m_ready  in  1  downstream accept
m_ch  out  CH_W  estimate channel
m_x_hat  out  WX  estimate
busy  out  1  FSM not IDLE
err_timeout  out  1  sticky, cleared by rst only
err_tag  out  1  sticky, cleared by rst only

Behaviour:
- Reset: all outputs 0; all contexts invalid (ctx_ok=0), x/P/Q/R=0; RR pointer=0; FSM=IDLE.
- cfg_we: writes x0,P0,Q,R into context cfg_ch and sets ctx_ok, any state, next cycle visible. cfg_ch >= N_CH ignored.
- Eligible channel: s_valid[i] && ctx_ok[i]. Invalid contexts never granted, s_ready[i] stays 0.
- FSM IDLE: if any eligible, grant first eligible at or after RR pointer (wrapping); s_ready[g]=1 combinationally this cycle; latch g, z, context; pointer <= g+1 mod N_CH; -> ISSUE.
- ISSUE: core_req_valid=1, core_* stable from latch; on core_req_ready -> WAIT, wait counter=0.
- WAIT: on core_rsp_valid with tag==g: write x,P to context g unless cfg_we targeted g since grant (cfg wins, result still emitted); load m_ch=g, m_x_hat=rsp_x; -> OUT. Tag mismatch: ignore, set err_tag, keep waiting. Counter reaching TIMEOUT: set err_timeout, no writeback, no output, -> IDLE.
- OUT: m_valid=1 with stable m_ch/m_x_hat until m_ready; handshake cycle -> IDLE (no grant in same cycle).
- Best-case throughput: IDLE(1)+ISSUE(>=1)+core latency+OUT(>=1) cycles; one request outstanding max.
- core_rsp_valid outside WAIT: ignored, sets err_tag.
- rst mid-operation: abandons in-flight update, no writeback; later core response ignored without flag only if arriving in the reset cycle.
- busy = (state != IDLE).

Decomposition:
- Package kf_pkg: WX/WP defaults, fractional widths (WF_X=15, WF_P=29), ONE_P constant (1<<29), state enum {IDLE, ISSUE, WAIT, OUT}.
- Sub-module kf_rr_arb: N_CH round-robin arbiter (req, pointer -> one-hot grant, index, any).

Test Plan:
- Reset: after rst, all outputs 0; s_valid=4'hF with no cfg -> s_ready stays 0 for 20 cycles.
- Single update: ch0 cfg x0=0, P0=R=1<<29, Q=0; behavioural core (K=P/(P+R), latency 8); z=1000 -> m_ch=0, m_x_hat=500, ctx P=1<<28; second z=1000 -> ~667.
- Fairness: all 4 channels configured, s_valid=4'hF held -> grant order 0,1,2,3,0,1; each channel's x independent.
- Backpressure: m_ready low 5 cycles -> m_valid, m_ch, m_x_hat held; no new s_ready until handshake.
- Errors: core never responds -> err_timeout=1 after 64 WAIT cycles, FSM IDLE, ctx unchanged; response tag 2 while waiting on 1 -> err_tag=1, correct later response still accepted.
- Collision/reset: cfg_we to in-flight channel during WAIT -> context equals cfg values, output still emitted; rst during WAIT -> outputs 0, context invalid.
